// File: rtl/wb_ram_mp_pkg.sv
// Shared decode and mask helpers for the multi-port, multi-bank Wishbone RAM.
// Widths are passed in so one package serves every parameterisation.
package wb_ram_mp_pkg;

   localparam int MAX_ADDR_W = 32;
   localparam int MAX_SEL_W  = 32;
   localparam int MAX_DATA_W = 8 * MAX_SEL_W;

   // Index width that never collapses to zero bits.
   function automatic int min1_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [MAX_ADDR_W-1:0] bank_of(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int addrW,
                                                     input int bankBits);
      if (bankBits == 0) return '0;
      return addr >> (addrW - bankBits);
   endfunction

   function automatic logic [MAX_ADDR_W-1:0] word_of(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int addrW,
                                                     input int bankBits,
                                                     input int selBits);
      logic [MAX_ADDR_W-1:0] lowMask;
      lowMask = (MAX_ADDR_W'(1) << (addrW - bankBits)) - MAX_ADDR_W'(1);
      return (addr & lowMask) >> selBits;
   endfunction

   function automatic logic [MAX_DATA_W-1:0] byte_mask(input logic [MAX_SEL_W-1:0] sel);
      logic [MAX_DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_SEL_W; i++) m[i*8 +: 8] = {8{sel[i]}};
      return m;
   endfunction

endpackage

// File: rtl/wb_ram_mp_if.sv
// Bundle of per-port pipelined Wishbone slave signals, one bit/field per port.
interface wb_ram_mp_if #(
   parameter int NPORTS = 2,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
);
   localparam int SEL_W = DATA_W / 8;

   logic [NPORTS-1:0]             wb_cyc_i;
   logic [NPORTS-1:0]             wb_stb_i;
   logic [NPORTS-1:0]             wb_we_i;
   logic [NPORTS-1:0][ADDR_W-1:0] wb_addr_i;
   logic [NPORTS-1:0][DATA_W-1:0] wb_data_i;
   logic [NPORTS-1:0][SEL_W-1:0]  wb_sel_i;
   logic [NPORTS-1:0]             wb_stall_o;
   logic [NPORTS-1:0]             wb_ack_o;
   logic [NPORTS-1:0][DATA_W-1:0] wb_data_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
      output wb_stall_o, wb_ack_o, wb_data_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
      input  wb_stall_o, wb_ack_o, wb_data_o
   );
endinterface

// File: rtl/wb_ram_bank.sv
// Single-port synchronous RAM bank with byte-enable writes and a 1-cycle read.
module wb_ram_bank #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W/8-1:0] sel,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
               if (sel[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
         rdata <= mem[addr];
      end
   end
endmodule

// File: rtl/wb_ram_mp.sv
// Multi-port Wishbone RAM: per-bank round-robin arbitration onto NBANKS word banks,
// so ports on different banks proceed together and only same-bank requests stall.
module wb_ram_mp
   import wb_ram_mp_pkg::*;
#(
   parameter int NPORTS = 2,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int NBANKS = 2
) (
   input  logic       wb_clk,
   input  logic       wb_reset_n,
   wb_ram_mp_if.slave wb
);
   localparam int SEL_W      = DATA_W / 8;
   localparam int SEL_BITS   = $clog2(SEL_W);
   localparam int BANK_BITS  = $clog2(NBANKS);
   localparam int BANK_W     = min1_clog2(NBANKS);
   localparam int PORT_W     = min1_clog2(NPORTS);
   localparam int WORD_W     = ADDR_W - SEL_BITS - BANK_BITS;
   localparam int BANK_DEPTH = 2**(ADDR_W - SEL_BITS) / NBANKS;

   logic [NPORTS-1:0][BANK_W-1:0] portBank;
   logic [NPORTS-1:0][WORD_W-1:0] portWord;
   logic [NBANKS-1:0][NPORTS-1:0] req;
   logic [NBANKS-1:0][NPORTS-1:0] bankGnt;
   logic [NBANKS-1:0][PORT_W-1:0] rr;
   logic [NBANKS-1:0][PORT_W-1:0] gntIdx;
   logic [NBANKS-1:0]             gntVld;
   logic [NPORTS-1:0]             grant;
   logic [NPORTS-1:0]             accept;
   int                            pIdx;

   logic [NBANKS-1:0]             bEn;
   logic [NBANKS-1:0]             bWe;
   logic [NBANKS-1:0][WORD_W-1:0] bAddr;
   logic [NBANKS-1:0][DATA_W-1:0] bWdata;
   logic [NBANKS-1:0][SEL_W-1:0]  bSel;
   logic [NBANKS-1:0][DATA_W-1:0] bankRdata;

   logic [NPORTS-1:0]             vld_p1;
   logic [NPORTS-1:0]             we_p1;
   logic [NPORTS-1:0][DATA_W-1:0] mask_p1;
   logic [NPORTS-1:0][BANK_W-1:0] bank_p1;

   // ---- stage p0: decode, arbitrate, drive banks ----
   always_comb begin
      portBank = '0;
      portWord = '0;
      req      = '0;
      for (int p = 0; p < NPORTS; p++) begin
         portBank[p] = BANK_W'(bank_of(MAX_ADDR_W'(wb.wb_addr_i[p]), ADDR_W, BANK_BITS));
         portWord[p] = WORD_W'(word_of(MAX_ADDR_W'(wb.wb_addr_i[p]), ADDR_W, BANK_BITS, SEL_BITS));
         for (int b = 0; b < NBANKS; b++) begin
            // Requests seen during reset are never granted.
            req[b][p] = wb.wb_cyc_i[p] & wb.wb_stb_i[p] & wb_reset_n &
                        (portBank[p] == BANK_W'(b));
         end
      end
   end

   always_comb begin
      bankGnt = '0;
      gntIdx  = '0;
      gntVld  = '0;
      pIdx    = 0;
      for (int b = 0; b < NBANKS; b++) begin
         for (int k = 0; k < NPORTS; k++) begin
            pIdx = int'(rr[b]) + k;
            if (pIdx >= NPORTS) pIdx = pIdx - NPORTS;
            if (!gntVld[b] && req[b][PORT_W'(pIdx)]) begin
               gntVld[b]                  = 1'b1;
               gntIdx[b]                  = PORT_W'(pIdx);
               bankGnt[b][PORT_W'(pIdx)]  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      grant = '0;
      for (int p = 0; p < NPORTS; p++) begin
         for (int b = 0; b < NBANKS; b++) grant[p] = grant[p] | bankGnt[b][p];
      end
      accept        = wb.wb_cyc_i & wb.wb_stb_i & grant;
      wb.wb_stall_o = wb.wb_cyc_i & wb.wb_stb_i & ~grant;
   end

   always_ff @(posedge wb_clk) begin
      if (!wb_reset_n) begin
         rr <= '0;
      end else begin
         for (int b = 0; b < NBANKS; b++) begin
            if (gntVld[b]) begin
               rr[b] <= (gntIdx[b] == PORT_W'(NPORTS - 1)) ? '0 : gntIdx[b] + PORT_W'(1);
            end
         end
      end
   end

   always_comb begin
      bEn    = '0;
      bWe    = '0;
      bAddr  = '0;
      bWdata = '0;
      bSel   = '0;
      for (int b = 0; b < NBANKS; b++) begin
         bEn[b]    = gntVld[b];
         bWe[b]    = gntVld[b] & wb.wb_we_i[gntIdx[b]];
         bAddr[b]  = portWord[gntIdx[b]];
         bWdata[b] = wb.wb_data_i[gntIdx[b]];
         bSel[b]   = wb.wb_sel_i[gntIdx[b]];
      end
   end

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      wb_ram_bank #(
         .DATA_W (DATA_W),
         .DEPTH  (BANK_DEPTH),
         .ADDR_W (WORD_W)
      ) u_bank (
         .clk   (wb_clk),
         .en    (bEn[b]),
         .we    (bWe[b]),
         .addr  (bAddr[b]),
         .wdata (bWdata[b]),
         .sel   (bSel[b]),
         .rdata (bankRdata[b])
      );
   end

   // ---- stage p1: ack/data return ----
   always_ff @(posedge wb_clk) begin
      if (!wb_reset_n) vld_p1 <= '0;
      else             vld_p1 <= accept;
   end

   always_ff @(posedge wb_clk) begin
      we_p1   <= wb.wb_we_i;
      bank_p1 <= portBank;
      for (int p = 0; p < NPORTS; p++) begin
         mask_p1[p] <= DATA_W'(byte_mask(MAX_SEL_W'(wb.wb_sel_i[p])));
      end
   end

   // Dropping cyc (abort) or asserting reset hides a pending ack and its data.
   always_comb begin
      wb.wb_ack_o  = vld_p1 & wb.wb_cyc_i & {NPORTS{wb_reset_n}};
      wb.wb_data_o = '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (wb.wb_ack_o[p] && !we_p1[p]) wb.wb_data_o[p] = bankRdata[bank_p1[p]] & mask_p1[p];
      end
   end
endmodule
